// File: rtl/sigmoid_lut_loader_pkg.sv
// Shared definitions for the sigmoid activation table: FSM state encoding and table sizing.
package sigmoid_lut_loader_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } lut_state_e;

    localparam int DEF_IN_WIDTH   = 10;
    localparam int DEF_DATA_WIDTH = 16;

    function automatic int lut_depth(input int in_width);
        return 1 << in_width;
    endfunction

endpackage

// File: rtl/sigmoid_lut_ram.sv
// Simple dual-port table RAM: one write port, one synchronous read port (read-during-write returns old data).
module sigmoid_lut_ram
    import sigmoid_lut_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_IN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [lut_depth(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sigmoid_lut_loader.sv
// Runtime-loadable sigmoid table with a 2-cycle lookup pipeline.
// Optional load-word checksum output enabled by defining SIGMOID_LUT_CHECKSUM_EN.
module sigmoid_lut_loader
    import sigmoid_lut_loader_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  load_done,
    output logic                  table_ok,
    input  logic                  lut_valid_in,
    input  logic [IN_WIDTH-1:0]   data_in,
    output logic                  lut_valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef SIGMOID_LUT_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output lut_state_e            dbg_state
);

    localparam int                  LUT_DEPTH = lut_depth(IN_WIDTH);
    localparam logic [IN_WIDTH-1:0] LAST_ADDR = IN_WIDTH'(LUT_DEPTH - 1);

    lut_state_e            state;
    logic [IN_WIDTH-1:0]   wr_addr;
    logic [IN_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic                  lookup_accept;
    logic                  rd_valid;

    // Load handshake: a word moves when load_valid && load_ready; a word beside load_start is dropped.
    assign wr_en         = load_valid && load_ready && !load_start;
    assign lookup_accept = lut_valid_in && (state == ST_READY) && !load_start;
    // Table is stored most-negative input first, so flipping the sign bit gives the address.
    assign rd_addr       = {~data_in[IN_WIDTH-1], data_in[IN_WIDTH-2:0]};
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            wr_addr    <= '0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
            table_ok   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (load_start) begin
                state      <= ST_LOAD;
                wr_addr    <= '0;
                load_ready <= 1'b1;
                table_ok   <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (wr_en) begin
                            if (wr_addr == LAST_ADDR) begin
                                state      <= ST_READY;
                                wr_addr    <= '0;
                                load_ready <= 1'b0;
                                load_done  <= 1'b1;
                                table_ok   <= 1'b1;
                            end else begin
                                wr_addr <= wr_addr + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // A reload cancels both pipeline stages so no lookup straddles a table rewrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid      <= 1'b0;
            lut_valid_out <= 1'b0;
            data_out      <= '0;
        end else begin
            rd_valid      <= lookup_accept;
            lut_valid_out <= rd_valid && !load_start;
            if (rd_valid && !load_start) begin
                data_out <= rd_data;
            end
        end
    end

`ifdef SIGMOID_LUT_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (load_start) begin
            checksum <= '0;
        end else if (wr_en) begin
            checksum <= checksum + load_data;
        end
    end
`endif

    sigmoid_lut_ram #(
        .ADDR_WIDTH(IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(load_data),
        .rd_en  (lookup_accept),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_sigmoid_lut_loader.sv
// Self-checking bench for sigmoid_lut_loader; define SIGMOID_LUT_CHECKSUM_EN to also cover the checksum port.
module tb_sigmoid_lut_loader;
  import sigmoid_lut_loader_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        table_ok;
  logic        lut_valid_in;
  logic [9:0]  data_in;
  logic        lut_valid_out;
  logic [15:0] data_out;
  lut_state_e  dbg_state;
`ifdef SIGMOID_LUT_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  sigmoid_lut_loader #(.IN_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_done    (load_done),
    .table_ok     (table_ok),
    .lut_valid_in (lut_valid_in),
    .data_in      (data_in),
    .lut_valid_out(lut_valid_out),
    .data_out     (data_out),
`ifdef SIGMOID_LUT_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_mem [1024];
  logic [15:0] words [1024];
  bit          m_ready = 1'b0;
  logic [15:0] exp_q [$];
  int          due_q [$];
  logic [15:0] last_out = '0;
  int          spur_cnt = 0;

  typedef struct {
    logic [9:0]  din;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Entry k holds sigmoid of signed input k-512, so input x lives at x+512.
  function automatic logic [15:0] model_val(input logic [9:0] din);
    int s;
    s = int'($signed(din));
    return model_mem[s + 512];
  endfunction

  task automatic purge_future();
    while (due_q.size() > 0 && due_q[$] > cyc) begin
      void'(due_q.pop_back());
      void'(exp_q.pop_back());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        logic [15:0] e;
        void'(due_q.pop_front());
        e = exp_q.pop_front();
        check("lut_valid", {31'd0, lut_valid_out}, 32'd1);
        check("lut_data", {16'd0, data_out}, {16'd0, e});
        last_out = e;
      end else if (lut_valid_out !== 1'b0) begin
        spur_cnt++;
        check("lut_spurious", {31'd0, lut_valid_out}, 32'd0);
      end else if (data_out !== last_out) begin
        check("data_hold", {16'd0, data_out}, {16'd0, last_out});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic lookup_exp(input logic [9:0] din, input logic [15:0] e);
    lut_valid_in = 1'b1;
    data_in      = din;
    if (m_ready) begin
      due_q.push_back(cyc + 2);
      exp_q.push_back(e);
    end
    @(negedge clk);
    lut_valid_in = 1'b0;
  endtask

  task automatic lookup(input logic [9:0] din);
    lookup_exp(din, model_val(din));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  task automatic load_table(input int mode, input int n_words);
    int   idx = 0;
    int   budget = 0;
    bit   bad_ready = 1'b0;
    bit   bad_flag = 1'b0;
    bit   v;
    bit   acc;
    logic [15:0] sum = '0;
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'($urandom);
    m_ready    = 1'b0;
    purge_future();
    @(negedge clk);
    load_start = 1'b0;
    while (idx < n_words && budget < 6000) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (budget % 2 == 0) : 1'($urandom_range(0, 1));
      load_valid = v;
      load_data  = words[idx];
      if (load_ready !== 1'b1) bad_ready = 1'b1;
      if (load_done !== 1'b0 || table_ok !== 1'b0) bad_flag = 1'b1;
      acc = v && (load_ready === 1'b1);
      @(negedge clk);
      if (acc) begin
        sum = sum + words[idx];
        idx++;
      end
      budget++;
    end
    load_valid = 1'b0;
    check("load_words_accepted", idx, n_words);
    check("load_ready_during_load", {31'd0, bad_ready}, 32'd0);
    check("no_early_done", {31'd0, bad_flag}, 32'd0);
    for (int i = 0; i < idx; i++) model_mem[i] = words[i];
    if (n_words == 1024) begin
      check("load_done_pulse", {31'd0, load_done}, 32'd1);
      check("table_ok_after_load", {31'd0, table_ok}, 32'd1);
      check("load_ready_after_load", {31'd0, load_ready}, 32'd0);
      check("state_ready", 32'(dbg_state), 32'(ST_READY));
`ifdef SIGMOID_LUT_CHECKSUM_EN
      check("checksum_at_done", {16'd0, checksum}, {16'd0, sum});
`endif
      m_ready = 1'b1;
      @(negedge clk);
      check("load_done_one_cycle", {31'd0, load_done}, 32'd0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int spur0;
    int budget;
    rst_n        = 1'b0;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    lut_valid_in = 1'b0;
    data_in      = '0;
    vecs[0] = '{10'h200, 16'd0};
    vecs[1] = '{10'h3ff, 16'd511};
    vecs[2] = '{10'h000, 16'd512};
    vecs[3] = '{10'h1ff, 16'd1023};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_table_ok", {31'd0, table_ok}, 32'd0);
    check("rst_lut_valid_out", {31'd0, lut_valid_out}, 32'd0);
    check("rst_data_out", {16'd0, data_out}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_EMPTY));
`ifdef SIGMOID_LUT_CHECKSUM_EN
    check("rst_checksum", {16'd0, checksum}, 32'd0);
`endif

    // Lookups before any load are dropped.
    spur0 = spur_cnt;
    repeat (4) lookup(10'd0);
    idle(4);
    check("empty_no_lookup_out", spur_cnt - spur0, 0);
    check("empty_table_ok", {31'd0, table_ok}, 32'd0);
    check("empty_load_ready", {31'd0, load_ready}, 32'd0);

    // Identity table, then the table-driven boundary lookups back to back.
    for (int k = 0; k < 1024; k++) words[k] = 16'(k);
    load_table(0, 1024);
    for (int i = 0; i < 4; i++) lookup_exp(vecs[i].din, vecs[i].exp);
    idle(4);

    // Gapped load with random words; the most positive input must return the last word.
    for (int k = 0; k < 1024; k++) words[k] = 16'($urandom);
    load_table(1, 1024);
    lookup(10'h1ff);
    lookup(10'h200);
    idle(3);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) != 0) lookup(10'($urandom));
      else idle(1);
    end
    idle(3);

    // Aborted partial load, restarted with a word presented beside load_start.
    for (int k = 0; k < 1024; k++) words[k] = 16'($urandom);
    load_table(2, 300);
    for (int k = 0; k < 1024; k++) words[k] = 16'($urandom);
    load_table(2, 1024);
    lookup(10'h200);
    lookup(10'h201);
    for (int i = 0; i < 20; i++) lookup(10'($urandom));
    idle(3);

    // Lookup in flight when a reload starts must not complete.
    lookup(10'($urandom));
    load_start = 1'b1;
    m_ready    = 1'b0;
    purge_future();
    @(negedge clk);
    load_start = 1'b0;
    check("cancel_no_valid", {31'd0, lut_valid_out}, 32'd0);
    check("cancel_table_ok", {31'd0, table_ok}, 32'd0);
    check("cancel_state_load", 32'(dbg_state), 32'(ST_LOAD));

`ifdef SIGMOID_LUT_CHECKSUM_EN
    for (int k = 0; k < 1024; k++) words[k] = 16'h0001;
    load_table(0, 1024);
`else
    for (int k = 0; k < 1024; k++) words[k] = 16'($urandom);
    load_table(0, 1024);
`endif
    for (int i = 0; i < 10; i++) lookup(10'($urandom));
    idle(3);

    // Reset in the middle of a load leaves the table unusable.
    load_table(0, 200);
    rst_n   = 1'b0;
    m_ready = 1'b0;
    due_q.delete();
    exp_q.delete();
    last_out = '0;
    @(negedge clk);
    check("midload_rst_table_ok", {31'd0, table_ok}, 32'd0);
    check("midload_rst_state", 32'(dbg_state), 32'(ST_EMPTY));
    rst_n = 1'b1;
    @(negedge clk);
    check("midload_rst_load_ready", {31'd0, load_ready}, 32'd0);
    spur0 = spur_cnt;
    repeat (3) lookup(10'($urandom));
    idle(4);
    check("midload_rst_no_out", spur_cnt - spur0, 0);

    budget = 0;
    while (due_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("scoreboard_drained", due_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
